// File: rtl/ring_pkg.sv
// Shared definitions for the ring counter / ring decoder pair.
package ring_pkg;

    // Default ring length, shared with the ring counter.
    localparam int unsigned RING_WIDTH = 8;

    // Decoder tracking states.
    typedef enum logic [1:0] {
        HUNT,
        CONFIRM,
        LOCKED
    } ring_state_t;

endpackage

// File: rtl/ring_onehot_check.sv
// Combinational one-hot checker: flags an exactly-one-bit pattern and
// encodes the position of that bit.
module ring_onehot_check #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_in,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    logic any;
    logic multi;

    // OR-encode every set bit; the index is only meaningful when valid.
    always_comb begin
        index = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                multi = multi | any;
                any   = 1'b1;
                index = index | IDX_W'(i);
            end
        end
        valid = any & ~multi;
    end

endmodule

// File: rtl/ring_decoder.sv
// Ring decoder: converts a one-hot ring count to a binary index, locks
// onto a rotate-left-by-one sequence and counts sequence errors.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = RING_WIDTH,
    parameter int unsigned IDX_W     = $clog2(WIDTH),
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 en,
    input  logic [WIDTH-1:0]     ring_in,
    input  logic                 clr_err,
    output logic [IDX_W-1:0]     idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);

    ring_state_t      state;
    ring_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             samp_valid;
    logic [IDX_W-1:0] samp_idx;
    logic [IDX_W-1:0] exp_idx;
    logic             step_ok;
    logic             err_event;

    ring_onehot_check #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_check (
        .ring_in (ring_in),
        .valid   (samp_valid),
        .index   (samp_idx)
    );

    // The expected next position wraps from the top bit back to bit 0.
    assign exp_idx = (idx == IDX_W'(WIDTH - 1)) ? '0 : idx + IDX_W'(1);
    assign step_ok = samp_valid && (samp_idx == exp_idx);

    // State and step-counter register.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            state <= HUNT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; errors are only raised from LOCKED.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        err_event  = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    if (samp_valid) begin
                        state_next = CONFIRM;
                        cnt_next   = '0;
                    end
                end
                CONFIRM: begin
                    if (!samp_valid) begin
                        state_next = HUNT;
                        cnt_next   = '0;
                    end else if (step_ok) begin
                        cnt_next = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(LOCK_CNT - 1)) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (!step_ok) begin
                        err_event  = 1'b1;
                        state_next = samp_valid ? CONFIRM : HUNT;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = HUNT;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Lock indication decoded straight from the state register.
    always_comb begin
        locked = (state == LOCKED);
    end

    // Index, validity, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (!init_n) begin
            idx       <= '0;
            idx_valid <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            step_err <= err_event;
            if (en) begin
                idx_valid <= samp_valid;
                if (samp_valid) begin
                    idx <= samp_idx;
                end
            end
            // A clear coinciding with a new error leaves that error counted.
            if (clr_err) begin
                err_count <= err_event ? ERR_CNT_W'(1) : '0;
            end else if (err_event && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule
